egret_axil_master: RTL and testbench
====================================

EGRET_AXIL_MASTER -- requirements
Module: egret_axil_master
Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width of the command, response and AXI data paths.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 7, byte-address width of the command and AXI address paths.
REQ-003 SHALL have M_AXI_ACLK  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have cmd_valid  in  1  command request.
REQ-006 SHALL have cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have cmd_write  in  1  1 = write, 0 = read.
REQ-008 SHALL have cmd_addr  in  ADDR_WIDTH  byte address.
REQ-009 SHALL have cmd_wdata  in  DATA_WIDTH  write data.
REQ-010 SHALL have cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have rsp_valid  out  1  response available.
REQ-012 SHALL have rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-013 SHALL have rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have rsp_resp  out  2  captured BRESP or RRESP.
REQ-015 SHALL have M_AXI_AWADDR  out  ADDR_WIDTH;  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1.
REQ-016 SHALL have M_AXI_WDATA  out  DATA_WIDTH;  M_AXI_WSTRB  out  DATA_WIDTH/8;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1.
REQ-017 SHALL have M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1.
REQ-018 SHALL have M_AXI_ARADDR  out  ADDR_WIDTH;  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1.
REQ-019 SHALL have M_AXI_RDATA  in  DATA_WIDTH;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1.
REQ-020 SHALL have M_AXI_AWPROT and M_AXI_ARPROT  out  3  driven constant 3'b000.
Function
REQ-021 SHALL implement FSM IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP; at most one transaction outstanding.
REQ-022 SHALL assert cmd_ready only in IDLE; on cmd_valid&cmd_ready register addr/wdata/wstrb and go WADDR_DATA (write) or RADDR (read).
REQ-023 SHALL drive all M_AXI_* outputs from registers only; no combinational path from cmd_* or M_AXI_* inputs to M_AXI_* outputs.
REQ-024 WADDR_DATA: AWVALID and WVALID high from the cycle after acceptance; each drops the cycle after its own READY is sampled high, independently; AW and W completing in the same cycle is legal; when both are done go WRESP.
REQ-025 SHALL hold AWADDR/WDATA/WSTRB/ARADDR stable while the corresponding VALID is high.
REQ-026 WRESP: BREADY high; on BVALID capture BRESP to rsp_resp, set rsp_rdata=0, go RSP.
REQ-027 RADDR: ARVALID high until ARREADY sampled, then RDATA with RREADY high; on RVALID capture RDATA/RRESP, go RSP.
REQ-028 RSP: rsp_valid high, rsp_* stable until rsp_ready; then IDLE (cmd_ready high next cycle).
REQ-029 SHALL pass SLVERR/DECERR unchanged; no retry, no timeout.
REQ-030 Latency with zero-wait slave: command accepted cycle N -> AR/AW/W VALID at N+1 -> rsp_valid no earlier than N+3.
Reset
REQ-031 On ARESETN low (asynchronous): state IDLE, cmd_ready, rsp_valid, all AXI VALID/READY outputs 0, rsp_rdata/rsp_resp 0; in-flight transaction abandoned with no response; cmd_ready high first clock edge after release.
Verification
REQ-032 Write addr 0x08, data 0xA5A50001, strb 0xF, slave ready after 1 cycle -> one AW and one W handshake, BREADY high, rsp_resp=2'b00, rsp_rdata=0.
REQ-033 Read addr 0x0C, slave returns 0x20220224 -> ARADDR=0x0C, rsp_rdata=0x20220224, rsp_resp=2'b00.
REQ-034 WREADY 3 cycles before AWREADY -> WVALID drops after WREADY, AWVALID held until AWREADY, exactly one B accepted.
REQ-035 BRESP=2'b10 and rsp_ready held low 5 cycles -> rsp_resp=2'b10 stable, cmd_ready=0, no new AW/AR issued.
REQ-036 ARESETN low during WRESP -> all VALIDs/BREADY 0 immediately, no rsp_valid; new read after release completes normally.

Source files
------------

// File: rtl/egret_axil_master.sv
// rtl/egret_axil_master.sv - single-outstanding AXI4-Lite master behind a command/response handshake
module egret_axil_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 7
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR_DATA, S_WRESP, S_RADDR, S_RDATA, S_RSP
  } state_t;

  state_t                            r_state;
  logic                              r_cmd_ready;
  logic                              r_rsp_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                        r_rsp_resp;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic                              r_awvalid;
  logic                              r_wvalid;
  logic                              r_bready;
  logic                              r_arvalid;
  logic                              r_rready;

  // A channel counts as finished once its VALID is gone or is being accepted this cycle.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WADDR_DATA;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end
        end
        S_WADDR_DATA: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_egret_axil_master.sv
// tb/tb_egret_axil_master.sv - bench for egret_axil_master with an AXI-Lite slave and transaction-level model
module tb_egret_axil_master;
  localparam int DW = 32;
  localparam int AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [DW-1:0] M_AXI_WDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic          M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]    M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [DW-1:0] M_AXI_RDATA = '0;

  egret_axil_master #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave behaviour knobs: cycles of VALID before READY, cycles before B/R are offered.
  int         cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

  int            cyc = 0;
  int            aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
  int            aw_cyc = 0, w_cyc = 0;
  logic [AW-1:0] last_araddr = '0;

  // AXI-Lite slave: decides at the falling edge, drives just after the rising edge.
  initial begin : slave
    logic [DW-1:0] s_mem [32];
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_wstrb;
    logic          aw_done, w_done, b_pend, r_pend;
    int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic          nx_awready, nx_wready, nx_bvalid, nx_arready, nx_rvalid;
    logic [1:0]    nx_bresp, nx_rresp;
    logic [DW-1:0] nx_rdata;
    for (int i = 0; i < 32; i++) s_mem[i] = '0;
    s_mem[3] = 32'h20220224;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    nx_awready = 0; nx_wready = 0; nx_bvalid = 0; nx_arready = 0; nx_rvalid = 0;
    nx_bresp = 0; nx_rresp = 0; nx_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        nx_awready = 0; nx_wready = 0; nx_bvalid = 0; nx_arready = 0; nx_rvalid = 0;
      end else begin
        if (M_AXI_AWVALID) begin
          if (M_AXI_AWREADY) begin
            aw_hs++; aw_cyc = cyc; s_awaddr = M_AXI_AWADDR; aw_done = 1; aw_cnt = 0;
            nx_awready = (cfg_aw_d == 0);
          end else begin
            aw_cnt++; nx_awready = (aw_cnt >= cfg_aw_d);
          end
        end else begin
          aw_cnt = 0; nx_awready = (cfg_aw_d == 0);
        end
        if (M_AXI_WVALID) begin
          if (M_AXI_WREADY) begin
            w_hs++; w_cyc = cyc; s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; w_done = 1; w_cnt = 0;
            nx_wready = (cfg_w_d == 0);
          end else begin
            w_cnt++; nx_wready = (w_cnt >= cfg_w_d);
          end
        end else begin
          w_cnt = 0; nx_wready = (cfg_w_d == 0);
        end
        if (aw_done && w_done) begin
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) s_mem[s_awaddr[6:2]][8*i +: 8] = s_wdata[8*i +: 8];
          aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) begin b_hs++; nx_bvalid = 0; end
        if (b_pend) begin
          if (b_cnt >= cfg_b_d) begin nx_bvalid = 1; nx_bresp = cfg_bresp; b_pend = 0; end
          else b_cnt++;
        end
        if (M_AXI_ARVALID) begin
          if (M_AXI_ARREADY) begin
            ar_hs++; s_araddr = M_AXI_ARADDR; last_araddr = M_AXI_ARADDR; r_pend = 1; r_cnt = 0; ar_cnt = 0;
            nx_arready = (cfg_ar_d == 0);
          end else begin
            ar_cnt++; nx_arready = (ar_cnt >= cfg_ar_d);
          end
        end else begin
          ar_cnt = 0; nx_arready = (cfg_ar_d == 0);
        end
        if (M_AXI_RVALID && M_AXI_RREADY) nx_rvalid = 0;
        if (r_pend) begin
          if (r_cnt >= cfg_r_d) begin
            nx_rvalid = 1; nx_rdata = s_mem[s_araddr[6:2]]; nx_rresp = cfg_rresp; r_pend = 0;
          end else r_cnt++;
        end
      end
      @(posedge clk);
      #1;
      M_AXI_AWREADY = nx_awready; M_AXI_WREADY = nx_wready;
      M_AXI_BVALID = nx_bvalid; M_AXI_BRESP = nx_bresp;
      M_AXI_ARREADY = nx_arready;
      M_AXI_RVALID = nx_rvalid; M_AXI_RDATA = nx_rdata; M_AXI_RRESP = nx_rresp;
    end
  end

  // Transaction-level model: each command expects AW+W (or AR) until accepted, then B (or R),
  // then a response one cycle after that handshake held until consumed.
  initial begin : compare
    logic [DW-1:0] m_mem [32];
    logic [33:0]   q [$];
    logic          busy, rel_pend, rsp_due, ready_now;
    logic          exp_aw, exp_w, exp_b, exp_ar, exp_r, wr_phase;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [3:0]    e_wstrb;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_mem[3] = 32'h20220224;
    busy = 0; rel_pend = 1; rsp_due = 0;
    exp_aw = 0; exp_w = 0; exp_b = 0; exp_ar = 0; exp_r = 0; wr_phase = 0;
    e_addr = '0; e_wdata = '0; e_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk("rst_rsp_data", {rsp_rdata, rsp_resp}, 0);
        q.delete();
        busy = 0; rel_pend = 1; rsp_due = 0;
        exp_aw = 0; exp_w = 0; exp_b = 0; exp_ar = 0; exp_r = 0; wr_phase = 0;
      end else begin
        ready_now = !rel_pend && !busy;
        chk("cmd_ready", cmd_ready, ready_now);
        chk("rsp_valid", rsp_valid, rsp_due);
        if (rsp_due && q.size() > 0) begin
          chk("rsp_rdata", rsp_rdata, q[0][33:2]);
          chk("rsp_resp", rsp_resp, q[0][1:0]);
        end
        chk("awvalid", M_AXI_AWVALID, exp_aw);
        if (exp_aw) chk("awaddr", M_AXI_AWADDR, e_addr);
        chk("wvalid", M_AXI_WVALID, exp_w);
        if (exp_w) chk("wdata_wstrb", {M_AXI_WDATA, M_AXI_WSTRB}, {e_wdata, e_wstrb});
        chk("bready", M_AXI_BREADY, exp_b);
        chk("arvalid", M_AXI_ARVALID, exp_ar);
        if (exp_ar) chk("araddr", M_AXI_ARADDR, e_addr);
        chk("rready", M_AXI_RREADY, exp_r);
        chk("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);

        if (rsp_due && rsp_ready) begin void'(q.pop_front()); rsp_due = 0; busy = 0; end
        if (exp_b && M_AXI_BVALID) begin exp_b = 0; rsp_due = 1; end
        if (exp_r && M_AXI_RVALID) begin exp_r = 0; rsp_due = 1; end
        if (exp_aw && M_AXI_AWREADY) exp_aw = 0;
        if (exp_w && M_AXI_WREADY) exp_w = 0;
        if (wr_phase && !exp_aw && !exp_w) begin wr_phase = 0; exp_b = 1; end
        if (exp_ar && M_AXI_ARREADY) begin exp_ar = 0; exp_r = 1; end
        if (ready_now && cmd_valid) begin
          busy = 1; e_addr = cmd_addr; e_wdata = cmd_wdata; e_wstrb = cmd_wstrb;
          if (cmd_write) begin
            exp_aw = 1; exp_w = 1; wr_phase = 1;
            for (int i = 0; i < 4; i++)
              if (cmd_wstrb[i]) m_mem[cmd_addr[6:2]][8*i +: 8] = cmd_wdata[8*i +: 8];
            q.push_back({32'h0, cfg_bresp});
          end else begin
            exp_ar = 1;
            q.push_back({m_mem[cmd_addr[6:2]], cfg_rresp});
          end
        end
        rel_pend = 0;
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    logic acc;
    acc = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin @(posedge clk); #1; acc = 1; break; end
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    if (!acc) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic get_rsp(input int hold, output logic [DW-1:0] rd, output logic [1:0] rr, output int lat);
    logic found;
    found = 0; lat = 0; rd = 'x; rr = 'x;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin found = 1; break; end
      @(posedge clk); #1; lat++;
    end
    if (!found) chk("rsp_timeout", 0, 1);
    else begin
      repeat (hold) @(posedge clk);
      #1;
      rsp_ready = 1; rd = rsp_rdata; rr = rsp_resp;
      @(posedge clk); #1;
      rsp_ready = 0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [DW-1:0] rd;
    logic [1:0]    rr;
    int            lat, b_aw, b_w, b_b, b_ar;
    logic          found;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1 chk("cmd_ready_before_first_edge", cmd_ready, 0);
    @(posedge clk); #1;
    chk("cmd_ready_first_edge", cmd_ready, 1);

    cfg_aw_d = 1; cfg_w_d = 1; cfg_b_d = 0; cfg_bresp = 2'b00;
    b_aw = aw_hs; b_w = w_hs; b_b = b_hs;
    send_cmd(1, 7'h08, 32'hA5A50001, 4'hF);
    get_rsp(0, rd, rr, lat);
    chk("w08_aw_count", aw_hs - b_aw, 1);
    chk("w08_w_count", w_hs - b_w, 1);
    chk("w08_b_count", b_hs - b_b, 1);
    chk("w08_rdata", rd, 32'h0);
    chk("w08_resp", rr, 2'b00);

    cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_r_d = 0; cfg_rresp = 2'b00;
    send_cmd(0, 7'h0C, 32'h0, 4'h0);
    get_rsp(0, rd, rr, lat);
    chk("r0c_araddr", last_araddr, 7'h0C);
    chk("r0c_rdata", rd, 32'h20220224);
    chk("r0c_resp", rr, 2'b00);
    chk("r0c_latency", lat, 2);

    send_cmd(1, 7'h14, 32'hDEADBEEF, 4'hF);
    get_rsp(0, rd, rr, lat);
    chk("w14_latency", lat, 2);

    cfg_w_d = 1; cfg_aw_d = 4; cfg_b_d = 2;
    b_aw = aw_hs; b_w = w_hs; b_b = b_hs;
    send_cmd(1, 7'h04, 32'h0BADF00D, 4'hF);
    get_rsp(0, rd, rr, lat);
    chk("split_aw_after_w", aw_cyc - w_cyc, 3);
    chk("split_aw_count", aw_hs - b_aw, 1);
    chk("split_w_count", w_hs - b_w, 1);
    chk("split_b_count", b_hs - b_b, 1);

    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 1; cfg_bresp = 2'b10;
    b_aw = aw_hs; b_ar = ar_hs;
    send_cmd(1, 7'h18, 32'h12345678, 4'hF);
    get_rsp(5, rd, rr, lat);
    chk("slverr_resp", rr, 2'b10);
    chk("slverr_aw_count", aw_hs - b_aw, 1);
    chk("slverr_ar_count", ar_hs - b_ar, 0);

    cfg_bresp = 2'b00; cfg_b_d = 0;
    send_cmd(1, 7'h08, 32'h11223344, 4'b0101);
    get_rsp(1, rd, rr, lat);
    chk("strb_wr_resp", rr, 2'b00);
    cfg_ar_d = 1; cfg_r_d = 2; cfg_rresp = 2'b11;
    send_cmd(0, 7'h08, 32'h0, 4'h0);
    get_rsp(2, rd, rr, lat);
    chk("strb_rd_rdata", rd, 32'hA5220044);
    chk("strb_rd_resp", rr, 2'b11);

    cfg_ar_d = 0; cfg_r_d = 0; cfg_rresp = 2'b00; cfg_b_d = 20;
    send_cmd(1, 7'h10, 32'h00000055, 4'hF);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (M_AXI_BREADY) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("wresp_reached", found, 1);
    rst_n = 0;
    #1;
    chk("async_rst_bready", M_AXI_BREADY, 0);
    chk("async_rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_cmd_ready", cmd_ready, 0);
    cfg_b_d = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 chk("rerelease_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    send_cmd(0, 7'h0C, 32'h0, 4'h0);
    get_rsp(0, rd, rr, lat);
    chk("post_rst_rdata", rd, 32'h20220224);
    chk("post_rst_resp", rr, 2'b00);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
